// File: rtl/tdc_pkg.sv
// Shared TDC definitions for the TOA fine-result path.
//  - FINE_BINS / FINE_ERR_CODE: fine interpolator range and its error code
//  - result word layout helpers: {enc_err, bubble_err[1:0], toa[TOA_W-1:0]}
//  - sat_inc: saturating counter next-state with clear priority
package tdc_pkg;

    localparam int unsigned FINE_W        = 6;
    localparam int unsigned FINE_BINS     = 63;
    localparam logic [5:0]  FINE_ERR_CODE = 6'd63;
    // Flag bits stacked above the TOA field: two bubble flags plus enc_err.
    localparam int unsigned RES_FLAG_W    = 3;

    function automatic int unsigned toa_width(input int unsigned coarse_w);
        return coarse_w + FINE_W;
    endfunction

    function automatic int unsigned res_width(input int unsigned coarse_w);
        return toa_width(coarse_w) + RES_FLAG_W;
    endfunction

    // Counters are at most 32 bits wide; callers cast in and out.
    function automatic logic [31:0] sat_inc(input logic [31:0] cur,
                                            input logic [31:0] max_val,
                                            input logic        clr,
                                            input logic        inc);
        if (clr) begin
            return '0;
        end
        if (inc && (cur != max_val)) begin
            return cur + 32'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/toa_skid_fifo.sv
// Two-entry synchronous FIFO used as the TOA result output queue.
//  clk, rstn       clock, asynchronous active-low reset
//  push, push_data write request; accepted when not full, or when full with a same-cycle pop
//  pop             read request; ignored when empty
//  full, empty     occupancy status
//  head            oldest entry, zero when empty
module toa_skid_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign pop_ok  = pop & ~empty;
    // When full, the slot being popped is the one written, so push+pop is safe.
    assign push_ok = push & (~full | pop_ok);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/toa_fine_result_pipe.sv
// TOA fine-result pipe: registers encoder output (S1), forms the linear TOA word
// (coarse*63 + fine, all-ones on encode error), queues results in a 2-entry FIFO with
// valid/ready handshake and keeps saturating per-cause error counters.
//  clk, rstn            clock, asynchronous active-low reset
//  en, hit_valid        capture qualifiers for fine_code / bubble_err / coarse_cnt
//  out_valid/ready/data result handshake, out_data = {enc_err, bubble_err, toa}
//  overflow             1-cycle pulse when a result is dropped on a full queue
//  clr_cnt              synchronous clear of the error counters (wins over increment)
//  bubA/bubB/encerr/drop_cnt  saturating error counters
module toa_fine_result_pipe
    import tdc_pkg::*;
#(
    parameter int unsigned COARSE_W = 10,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned TOA_W   = toa_width(COARSE_W),
    localparam int unsigned RES_W   = res_width(COARSE_W)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                hit_valid,
    input  logic [5:0]          fine_code,
    input  logic [1:0]          bubble_err,
    input  logic [COARSE_W-1:0] coarse_cnt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    out_data,
    output logic                overflow,
    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    bubA_cnt,
    output logic [CNT_W-1:0]    bubB_cnt,
    output logic [CNT_W-1:0]    encerr_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    // S1 capture
    logic                s1_vld_q;
    logic [5:0]          s1_fine_q;
    logic [1:0]          s1_bub_q;
    logic [COARSE_W-1:0] s1_coarse_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld_q    <= 1'b0;
            s1_fine_q   <= '0;
            s1_bub_q    <= '0;
            s1_coarse_q <= '0;
        end else begin
            s1_vld_q <= en & hit_valid;
            if (en && hit_valid) begin
                s1_fine_q   <= fine_code;
                s1_bub_q    <= bubble_err;
                s1_coarse_q <= coarse_cnt;
            end
        end
    end

    // S2 arithmetic: coarse*63 as (coarse<<6) - coarse, no multiplier.
    logic             enc_err;
    logic [TOA_W-1:0] toa_lin;
    logic [TOA_W-1:0] toa;
    logic [RES_W-1:0] res;

    assign enc_err = (s1_fine_q == FINE_ERR_CODE);
    assign toa_lin = {s1_coarse_q, 6'b0} - TOA_W'(s1_coarse_q) + TOA_W'(s1_fine_q);
    assign toa     = enc_err ? '1 : toa_lin;
    assign res     = {enc_err, s1_bub_q, toa};

    // Output queue
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic drop;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign drop      = s1_vld_q & fifo_full & ~pop;

    toa_skid_fifo #(
        .WIDTH (RES_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (s1_vld_q),
        .push_data (res),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data)
    );

    // Overflow pulse and error counters
    logic             overflow_q;
    logic [CNT_W-1:0] bub_a_q, bub_a_d;
    logic [CNT_W-1:0] bub_b_q, bub_b_d;
    logic [CNT_W-1:0] enc_q, enc_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        bub_a_d = CNT_W'(sat_inc(32'(bub_a_q), CNT_MAX, clr_cnt, s1_vld_q & s1_bub_q[1]));
        bub_b_d = CNT_W'(sat_inc(32'(bub_b_q), CNT_MAX, clr_cnt, s1_vld_q & s1_bub_q[0]));
        enc_d   = CNT_W'(sat_inc(32'(enc_q), CNT_MAX, clr_cnt, s1_vld_q & enc_err));
        drop_d  = CNT_W'(sat_inc(32'(drop_q), CNT_MAX, clr_cnt, drop));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
            bub_a_q    <= '0;
            bub_b_q    <= '0;
            enc_q      <= '0;
            drop_q     <= '0;
        end else begin
            overflow_q <= drop;
            bub_a_q    <= bub_a_d;
            bub_b_q    <= bub_b_d;
            enc_q      <= enc_d;
            drop_q     <= drop_d;
        end
    end

    assign overflow   = overflow_q;
    assign bubA_cnt   = bub_a_q;
    assign bubB_cnt   = bub_b_q;
    assign encerr_cnt = enc_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_toa_fine_result_pipe.sv
module tb_toa_fine_result_pipe;

    localparam int COARSE_W = 10;
    localparam int CNT_W    = 16;
    localparam int RES_W    = COARSE_W + 9;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                en = 1'b1;
    logic                hit_valid = 1'b0;
    logic [5:0]          fine_code = '0;
    logic [1:0]          bubble_err = '0;
    logic [COARSE_W-1:0] coarse_cnt = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [RES_W-1:0]    out_data;
    logic                overflow;
    logic                clr_cnt = 1'b0;
    logic [CNT_W-1:0]    bubA_cnt, bubB_cnt, encerr_cnt, drop_cnt;

    toa_fine_result_pipe #(
        .COARSE_W (COARSE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .hit_valid  (hit_valid),
        .fine_code  (fine_code),
        .bubble_err (bubble_err),
        .coarse_cnt (coarse_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overflow   (overflow),
        .clr_cnt    (clr_cnt),
        .bubA_cnt   (bubA_cnt),
        .bubB_cnt   (bubB_cnt),
        .encerr_cnt (encerr_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected result word straight from the arithmetic definition.
    function automatic logic [RES_W-1:0] mk_word(input int coarse, input int fine,
                                                 input logic [1:0] bub);
        logic [15:0] t;
        if (fine == 63) return {1'b1, bub, 16'hFFFF};
        t = 16'(coarse * 63 + fine);
        return {1'b0, bub, t};
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Transaction-level model: pending result, FIFO contents, counters.
    logic [RES_W-1:0] mq[$];
    bit               pend_v = 0;
    logic [RES_W-1:0] pend_w = '0;
    int               m_bub_a = 0, m_bub_b = 0, m_enc = 0, m_drop = 0;
    bit               m_ov = 0;
    bit               m_pop, m_drp;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            pend_v  = 0;
            m_bub_a = 0; m_bub_b = 0; m_enc = 0; m_drop = 0;
            m_ov    = 0;
        end else begin
            m_pop = (mq.size() > 0) && out_ready;
            m_drp = pend_v && (mq.size() == 2) && !m_pop;
            if (m_pop) void'(mq.pop_front());
            if (pend_v && !m_drp) mq.push_back(pend_w);
            if (clr_cnt) begin
                m_bub_a = 0; m_bub_b = 0; m_enc = 0; m_drop = 0;
            end else begin
                if (pend_v && pend_w[RES_W-2]) m_bub_a = sat(m_bub_a);
                if (pend_v && pend_w[RES_W-3]) m_bub_b = sat(m_bub_b);
                if (pend_v && pend_w[RES_W-1]) m_enc   = sat(m_enc);
                if (m_drp) m_drop = sat(m_drop);
            end
            m_ov   = m_drp;
            pend_v = en && hit_valid;
            pend_w = mk_word(int'(coarse_cnt), int'(fine_code), bubble_err);
        end
    end

    // Per-cycle compare plus capture of popped words.
    logic [RES_W-1:0] got[$];
    bit               rec_en = 1;

    always @(negedge clk) begin
        check("out_valid", out_valid, (mq.size() > 0));
        if (mq.size() > 0) check("out_data", out_data, mq[0]);
        check("overflow", overflow, m_ov);
        check("bubA_cnt", bubA_cnt, m_bub_a);
        check("bubB_cnt", bubB_cnt, m_bub_b);
        check("encerr_cnt", encerr_cnt, m_enc);
        check("drop_cnt", drop_cnt, m_drop);
        if (rec_en && out_valid && out_ready) got.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input int coarse, input int fine, input logic [1:0] bub);
        hit_valid  = 1'b1;
        coarse_cnt = COARSE_W'(coarse);
        fine_code  = 6'(fine);
        bubble_err = bub;
        tick();
        hit_valid  = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_encerr", encerr_cnt, 0);
        check("reset_overflow", overflow, 0);
        rstn = 1'b1;
        tick();

        // Basic latency and TOA value.
        out_ready = 1'b1;
        hit(5, 17, 2'b00);
        check("t1_not_yet_valid", out_valid, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 19'd332);
        tick();

        // Encode error with A-window bubble.
        hit(7, 63, 2'b10);
        tick();
        check("t2_data", out_data, {1'b1, 2'b10, 16'hFFFF});
        tick();
        check("t2_encerr", encerr_cnt, 1);
        check("t2_bubA", bubA_cnt, 1);
        check("t2_bubB", bubB_cnt, 0);

        // Overflow with consumer stalled.
        out_ready = 1'b0;
        got.delete();
        hit(1, 0, 2'b00);
        hit(2, 1, 2'b01);
        hit(3, 2, 2'b00);
        tick();
        check("t3_overflow", overflow, 1);
        check("t3_drop_cnt", drop_cnt, 1);
        tick();
        check("t3_overflow_end", overflow, 0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("t3_pops", got.size(), 2);
        if (got.size() == 2) begin
            check("t3_first", got[0], 19'd63);
            check("t3_second", got[1], {1'b0, 2'b01, 16'd127});
        end

        // Full queue, push and pop on the same edge.
        out_ready = 1'b0;
        got.delete();
        hit(4, 3, 2'b00);
        hit(5, 4, 2'b10);
        hit(6, 5, 2'b00);
        out_ready = 1'b1;
        tick();
        check("t4_no_overflow", overflow, 0);
        check("t4_drop_cnt", drop_cnt, 1);
        repeat (4) tick();
        check("t4_pops", got.size(), 3);
        if (got.size() == 3) begin
            check("t4_first", got[0], 19'd255);
            check("t4_second", got[1], {1'b0, 2'b10, 16'd319});
            check("t4_third", got[2], 19'd383);
        end

        // Encode-error counter saturation, then clear beating a same-cycle increment.
        rec_en  = 0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt    = 1'b0;
        hit_valid  = 1'b1;
        coarse_cnt = '0;
        fine_code  = 6'd63;
        bubble_err = 2'b00;
        repeat (65535) tick();
        hit_valid = 1'b0;
        repeat (2) tick();
        check("t5_encerr_max", encerr_cnt, 16'hFFFF);
        hit(9, 63, 2'b00);
        repeat (2) tick();
        check("t5_encerr_sat", encerr_cnt, 16'hFFFF);
        hit(9, 63, 2'b11);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t5_clr_wins", encerr_cnt, 0);
        check("t5_clr_bubA", bubA_cnt, 0);
        repeat (3) tick();

        // Async reset with two queued entries and S1 occupied.
        out_ready = 1'b0;
        hit(1, 1, 2'b01);
        hit(2, 2, 2'b01);
        hit(3, 3, 2'b01);
        check("t6_pre_valid", out_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_bubB", bubB_cnt, 0);
        check("t6_rst_overflow", overflow, 0);
        tick();
        rstn = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("t6_after_valid", out_valid, 0);

        // Capture disabled.
        en = 1'b0;
        hit(4, 63, 2'b11);
        hit(5, 63, 2'b11);
        repeat (3) tick();
        check("t7_valid", out_valid, 0);
        check("t7_encerr", encerr_cnt, 0);
        check("t7_bubA", bubA_cnt, 0);
        en = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
